// File: rtl/rx_byte_fifo.sv
// Receive buffer behind the UART: captures each received byte with its error tags
// into a FWFT FIFO, acks the UART once per byte, and tracks dropped bytes.
module rx_byte_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rxData,
    input  logic                  dataOutReadyFlag,
    input  logic                  frameErrorFlag,
    input  logic                  overrunErrorFlag,
    output logic                  ackFlags,
    output logic [7:0]            popData,
    output logic                  popFrameErr,
    output logic                  popOverrun,
    output logic                  popValid,
    input  logic                  popReady,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflowFlag,
    input  logic                  clearOverflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1'b1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } cap_state_t;

    cap_state_t            state_r;
    logic                  ack_r;
    logic                  overflow_r;
    logic                  valid_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [9:0]            mem_r [DEPTH];

    logic                  capture_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic [DEPTH_LOG2:0]   count_next_s;
    logic [9:0]            head_s;

    // Capture/pop qualification and next occupancy; a full FIFO still accepts a push when a pop frees the slot
    always_comb begin
        capture_s    = 1'b0;
        pop_s        = 1'b0;
        push_s       = 1'b0;
        drop_s       = 1'b0;
        count_next_s = count_r;
        capture_s    = (state_r == IDLE) && (dataOutReadyFlag || frameErrorFlag);
        pop_s        = valid_r && popReady;
        push_s       = capture_s && ((count_r != FULL_COUNT) || pop_s);
        drop_s       = capture_s && !push_s;
        if (flush) begin
            count_next_s = '0;
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Entry storage; a push coinciding with flush is discarded
    always_ff @(posedge clk) begin
        if (push_s && !flush && !reset) begin
            mem_r[wr_ptr_r] <= {overrunErrorFlag, frameErrorFlag, rxData};
        end
    end

    // Pointers, occupancy and the registered non-empty flag
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != '0);
        end
    end

    // Capture FSM: one ack per byte, then hold off until the UART drops its flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (capture_s) begin
                        state_r <= ACK;
                        ack_r   <= 1'b1;
                    end else begin
                        ack_r   <= 1'b0;
                    end
                end
                ACK: begin
                    state_r <= WAIT;
                    ack_r   <= 1'b0;
                end
                WAIT: begin
                    ack_r <= 1'b0;
                    if (!dataOutReadyFlag && !frameErrorFlag) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ack_r   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky drop indicator; a new drop wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clearOverflow) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign head_s       = mem_r[rd_ptr_r];
    assign popData      = head_s[7:0];
    assign popFrameErr  = head_s[8];
    assign popOverrun   = head_s[9];
    assign popValid     = valid_r;
    assign count        = count_r;
    assign ackFlags     = ack_r;
    assign overflowFlag = overflow_r;

endmodule
